// File: rtl/nonrestoring_divider_pkg.sv
// Shared types for the sequential non-restoring divider.
// State encoding is fixed so waveforms read the same across builds.
package nonrestoring_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/nonrestoring_divider_if.sv
// Request/result handshake bundle for the divider.
// master = requester/consumer, slave = divider.
interface nonrestoring_divider_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/nonrestoring_divider_addsub_step.sv
// One WIDTH+1 bit add/sub step: sum = a + (b ^ sub) + sub.
// Carry out is dropped; the caller reads the sign from sum[WIDTH].
module div_addsub_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  input  logic           sub,
  output logic [WIDTH:0] sum
);

  logic [WIDTH:0] b_x;

  assign b_x = b ^ {(WIDTH+1){sub}};
  assign sum = a + b_x + {{WIDTH{1'b0}}, sub};

endmodule

// File: rtl/nonrestoring_divider.sv
// Sequential unsigned non-restoring divider, one quotient bit per clock.
// A single add/sub step serves both the RUN iterations and the FIX pass.
module nonrestoring_divider
  import nonrestoring_divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  nonrestoring_divider_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  div_state_e       state;
  logic [WIDTH:0]   r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic [CW-1:0]    cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic             dbz_q;

  logic [WIDTH:0]   step_a;
  logic [WIDTH:0]   step_b;
  logic             step_sub;
  logic [WIDTH:0]   step_sum;
  logic             accept;

  assign accept = bus.in_valid & in_ready_q;
  assign step_b = {1'b0, d_q};

  // FIX adds D back onto R; RUN shifts and picks add/sub from R's sign.
  always_comb begin
    step_a   = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    step_sub = ~r_q[WIDTH];
    if (state == FIX) begin
      step_a   = r_q;
      step_sub = 1'b0;
    end
  end

  div_addsub_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .a  (step_a),
    .b  (step_b),
    .sub(step_sub),
    .sum(step_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      quo_q       <= '0;
      rem_q       <= '0;
      dbz_q       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            in_ready_q <= 1'b0;
            if (bus.divisor == '0) begin
              quo_q       <= '1;
              rem_q       <= bus.dividend;
              dbz_q       <= 1'b1;
              out_valid_q <= 1'b1;
              state       <= DONE;
            end else begin
              r_q   <= '0;
              q_q   <= bus.dividend;
              d_q   <= bus.divisor;
              cnt_q <= '0;
              state <= RUN;
            end
          end
        end
        RUN: begin
          r_q   <= step_sum;
          q_q   <= {q_q[WIDTH-2:0], ~step_sum[WIDTH]};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1))
            state <= FIX;
        end
        FIX: begin
          if (r_q[WIDTH])
            r_q <= step_sum;
          quo_q       <= q_q;
          rem_q       <= r_q[WIDTH] ? step_sum[WIDTH-1:0]
                                    : r_q[WIDTH-1:0];
          dbz_q       <= 1'b0;
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Directed and sweep checks for the 4-bit non-restoring divider.
// Inputs change and outputs are sampled on the falling edge.
module tb_nonrestoring_divider;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  nonrestoring_divider_if #(.WIDTH(4)) bus ();

  nonrestoring_divider #(
    .WIDTH(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] res();
    return {7'd0, bus.div_by_zero, bus.quotient, bus.remainder};
  endfunction

  function automatic logic [15:0] ref_res(input logic [3:0] a,
                                          input logic [3:0] b);
    if (b == 4'd0) return {7'd0, 1'b1, 4'hf, a};
    return {7'd0, 1'b0, 4'(a / b), 4'(a % b)};
  endfunction

  // Waits for in_ready, issues a request, returns edges (accept edge
  // counted as 1) until out_valid is seen.
  task automatic send(input logic [3:0] a, input logic [3:0] b,
                      output int lat);
    int n;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_req", 16'(bus.in_ready), 16'd1);
    bus.in_valid = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("out_valid_seen", 16'(bus.out_valid), 16'd1);
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("out_valid_drop", 16'(bus.out_valid), 16'd0);
  endtask

  task automatic run_one(input string tag, input logic [3:0] a,
                         input logic [3:0] b, input int exp_lat);
    int lat;
    send(a, b, lat);
    check({tag, "_lat"}, 16'(lat), 16'(exp_lat));
    check({tag, "_res"}, res(), ref_res(a, b));
    take();
  endtask

  initial begin
    int lat;
    int n;
    n_checks = 0;
    n_fail   = 0;
    rst_n         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
    #2 rst_n = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_in_ready", 16'(bus.in_ready), 16'd0);
    check("rst_out_valid", 16'(bus.out_valid), 16'd0);
    check("rst_res", res(), 16'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 16'(bus.in_ready), 16'd1);

    run_one("d13_3", 4'd13, 4'd3, 6);
    check("d13_3_q", 16'(bus.quotient), 16'd4);
    check("d13_3_r", 16'(bus.remainder), 16'd1);
    run_one("d15_1", 4'd15, 4'd1, 6);
    run_one("d2_7", 4'd2, 4'd7, 6);
    run_one("d0_5", 4'd0, 4'd5, 6);
    run_one("d9_0", 4'd9, 4'd0, 1);
    check("d9_0_dbz", 16'(bus.div_by_zero), 16'd1);

    // Back-pressure: result must hold while out_ready is low.
    send(4'd11, 4'd2, lat);
    check("d11_2_lat", 16'(lat), 16'd6);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_valid", 16'(bus.out_valid), 16'd1);
      check("hold_res", res(), {7'd0, 1'b0, 4'd5, 4'd1});
      check("hold_in_ready", 16'(bus.in_ready), 16'd0);
    end
    take();

    // Requests during RUN are ignored.
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b1;
    bus.dividend = 4'd13;
    bus.divisor  = 4'd3;
    @(negedge clk);
    bus.dividend = 4'd7;
    bus.divisor  = 4'd7;
    check("busy_in_ready", 16'(bus.in_ready), 16'd0);
    repeat (2) @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("ignore_res", res(), {7'd0, 1'b0, 4'd4, 4'd1});
    take();

    // Reset during the second RUN cycle discards the division.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.dividend = 4'd13;
    bus.divisor  = 4'd3;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 16'(bus.out_valid), 16'd0);
    check("midrst_res", res(), 16'd0);
    check("midrst_in_ready", 16'(bus.in_ready), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("midrst_no_out", 16'(bus.out_valid), 16'd0);
    run_one("d6_4", 4'd6, 4'd4, 6);

    // Full operand sweep with random consumer stalls.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        send(4'(a), 4'(b), lat);
        check("sweep_lat", 16'(lat), (b == 0) ? 16'd1 : 16'd6);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        check("sweep_res", res(), ref_res(4'(a), 4'(b)));
        take();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
